// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: shares one single-port memory between the OTTER fetch (IF)
// and memory (MEM) stages. Data accesses win over fetches, one transaction is
// in flight at a time, and a watchdog frees the port if memory never answers.
module otter_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned TO_CNT_W       = 7,
   localparam int unsigned XLEN          = 32,
   localparam int unsigned SIZE_W        = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              if_req,
   input  logic [XLEN-1:0]   if_addr,
   output logic [XLEN-1:0]   if_rdata,
   output logic              if_valid,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [XLEN-1:0]   d_addr,
   input  logic [XLEN-1:0]   d_wdata,
   input  logic [SIZE_W-1:0] d_size,
   output logic [XLEN-1:0]   d_rdata,
   output logic              d_valid,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [SIZE_W-1:0] mem_size,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_ready,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              err_timeout
);

   localparam logic [SIZE_W-1:0] SIZE_WORD = SIZE_W'(2);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                mem_req_d, mem_we_d, err_d;
   logic [XLEN-1:0]     mem_addr_d, mem_wdata_d;
   logic [SIZE_W-1:0]   mem_size_d;
   logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic                to_hit;
   logic                d_pending;

   assign d_pending = d_read | d_write;

   // Watchdog fires on the last allowed busy cycle; a zero limit disables it
   assign to_hit = (TIMEOUT_CYCLES != 0) &&
                   (to_cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));

   // Stalls are released in the same cycle as the requester's completion strobe
   assign stall_if  = if_req && !if_valid;
   assign stall_mem = d_pending && !d_valid;

   // Next-state, latched request fields and completion strobes
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      mem_size_d  = mem_size;
      to_cnt_d    = to_cnt_q;
      err_d       = err_timeout;
      if_valid    = 1'b0;
      if_rdata    = '0;
      d_valid     = 1'b0;
      d_rdata     = '0;

      unique case (state_q)
         IDLE: begin
            if (d_pending) begin
               state_d     = BUSY_D;
               mem_req_d   = 1'b1;
               mem_we_d    = d_write;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_size_d  = d_size;
               to_cnt_d    = '0;
            end else if (if_req) begin
               state_d     = BUSY_I;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               mem_size_d  = SIZE_WORD;
               to_cnt_d    = '0;
            end
         end

         BUSY_I, BUSY_D: begin
            if (mem_ready || to_hit) begin
               // A real answer in the watchdog cycle still counts as a normal completion
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (!mem_ready) begin
                  err_d = 1'b1;
               end
               if (state_q == BUSY_D) begin
                  d_valid = 1'b1;
                  d_rdata = mem_ready ? mem_rdata : '0;
               end else begin
                  if_valid = 1'b1;
                  if_rdata = mem_ready ? mem_rdata : '0;
               end
            end else begin
               to_cnt_d = to_cnt_q + TO_CNT_W'(1);
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and request-field registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_size    <= '0;
         to_cnt_q    <= '0;
         err_timeout <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req     <= mem_req_d;
         mem_we      <= mem_we_d;
         mem_addr    <= mem_addr_d;
         mem_wdata   <= mem_wdata_d;
         mem_size    <= mem_size_d;
         to_cnt_q    <= to_cnt_d;
         err_timeout <= err_d;
      end
   end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Testbench for otter_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, latency and timeout.
module tb_otter_mem_arbiter;

   localparam int unsigned TO = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        d_read = 1'b0;
   logic        d_write = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [1:0]  d_size = '0;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_size;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        stall_if;
   logic        stall_mem;
   logic        err_timeout;

   int checks = 0;
   int errors = 0;

   otter_mem_arbiter #(.TIMEOUT_CYCLES(TO), .TO_CNT_W(3)) dut (
      .CLK(CLK), .RST(RST),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_size(d_size), .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_mem(stall_mem), .err_timeout(err_timeout)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      if_req    = 1'b0;
      d_read    = 1'b0;
      d_write   = 1'b0;
      mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      idle_inputs();
      tick();
      tick();
      checks++; if ({mem_req, mem_we, mem_size, err_timeout, if_valid, d_valid, stall_if, stall_mem} !== 9'd0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0", {mem_req, mem_we, mem_size, err_timeout, if_valid, d_valid, stall_if, stall_mem}); end
      checks++; if ({mem_addr, mem_wdata} !== 64'd0) begin errors++; $display("FAIL reset_fields: got %h expected 0", {mem_addr, mem_wdata}); end
      RST = 1'b0;
      tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_release_req: got %b expected 0", mem_req); end
   endtask

   task automatic test_load();
      idle_inputs();
      tick();
      d_read = 1'b1; d_addr = 32'h0000_0100; d_size = 2'd2;
      #1;
      checks++; if (stall_mem !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL load_accept: got stall=%b req=%b expected 1 0", stall_mem, mem_req); end
      tick();
      for (int k = 0; k < 4; k++) begin
         mem_ready = (k == 3);
         mem_rdata = (k == 3) ? 32'hCAFE_F00D : 32'hDEAD_0000 + 32'(k);
         #1;
         checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin errors++; $display("FAIL load_fields k=%0d: got req=%b we=%b addr=%h expected 1 0 00000100", k, mem_req, mem_we, mem_addr); end
         checks++; if (d_valid !== (k == 3) || stall_mem !== (k != 3) || if_valid !== 1'b0) begin errors++; $display("FAIL load_strobe k=%0d: got dv=%b stall=%b iv=%b", k, d_valid, stall_mem, if_valid); end
         if (k == 3) begin
            checks++; if (d_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL load_rdata: got %h expected cafef00d", d_rdata); end
         end
         if (k == 1) d_addr = 32'h0000_0999;
         tick();
      end
      d_read = 1'b0; mem_ready = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || d_valid !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL load_done: got req=%b dv=%b err=%b expected 0 0 0", mem_req, d_valid, err_timeout); end
   endtask

   task automatic test_contention();
      idle_inputs();
      tick();
      d_write = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'h1234_5678; d_size = 2'd2;
      if_req = 1'b1; if_addr = 32'h0000_0040;
      #1;
      checks++; if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin errors++; $display("FAIL cont_stalls: got %b%b expected 11", stall_if, stall_mem); end
      tick();
      #1;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h1234_5678 || mem_size !== 2'd2) begin errors++; $display("FAIL cont_store_fields: got req=%b we=%b addr=%h wd=%h sz=%0d", mem_req, mem_we, mem_addr, mem_wdata, mem_size); end
      tick();
      mem_ready = 1'b1; mem_rdata = 32'h0;
      #1;
      checks++; if (d_valid !== 1'b1 || if_valid !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL cont_store_done: got dv=%b iv=%b sif=%b expected 1 0 1", d_valid, if_valid, stall_if); end
      tick();
      d_write = 1'b0; mem_ready = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL cont_gap: got req=%b iv=%b expected 0 0", mem_req, if_valid); end
      tick();
      mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
      #1;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40 || mem_size !== 2'd2) begin errors++; $display("FAIL cont_fetch_fields: got req=%b we=%b addr=%h sz=%0d", mem_req, mem_we, mem_addr, mem_size); end
      checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h13 || stall_if !== 1'b0) begin errors++; $display("FAIL cont_fetch_done: got iv=%b rd=%h sif=%b expected 1 00000013 0", if_valid, if_rdata, stall_if); end
      tick();
      if_req = 1'b0; mem_ready = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL cont_end: got req=%b iv=%b expected 0 0", mem_req, if_valid); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] a;
      logic [31:0] rd;
      bit          is_d;
      idle_inputs();
      tick();
      mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         is_d = i[0];
         a = $urandom & 32'hFFFF_FFFC;
         if (is_d) begin d_read = 1'b1; d_addr = a; d_size = 2'd2; end
         else begin if_req = 1'b1; if_addr = a; end
         #1;
         checks++; if (mem_req !== 1'b0 || if_valid !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("FAIL zw_gap i=%0d: got req=%b iv=%b dv=%b expected 0 0 0", i, mem_req, if_valid, d_valid); end
         tick();
         rd = $urandom;
         mem_rdata = rd;
         #1;
         checks++; if (mem_req !== 1'b1 || mem_addr !== a) begin errors++; $display("FAIL zw_grant i=%0d: got req=%b addr=%h expected 1 %h", i, mem_req, mem_addr, a); end
         checks++; if (d_valid !== is_d || if_valid !== !is_d || (is_d ? d_rdata : if_rdata) !== rd) begin errors++; $display("FAIL zw_done i=%0d: got dv=%b iv=%b rd=%h expected %h", i, d_valid, if_valid, is_d ? d_rdata : if_rdata, rd); end
         tick();
         d_read = 1'b0; if_req = 1'b0;
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_both_rw();
      logic [31:0] a;
      logic [31:0] wd;
      idle_inputs();
      tick();
      for (int s = 0; s < 3; s++) begin
         a = $urandom; wd = $urandom;
         d_read = 1'b1; d_write = 1'b1; d_size = 2'(s); d_addr = a; d_wdata = wd;
         tick();
         mem_ready = 1'b1; mem_rdata = $urandom;
         #1;
         checks++; if (mem_we !== 1'b1 || mem_size !== 2'(s) || mem_addr !== a || mem_wdata !== wd) begin errors++; $display("FAIL rw_fields s=%0d: got we=%b sz=%0d addr=%h wd=%h", s, mem_we, mem_size, mem_addr, mem_wdata); end
         checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL rw_valid s=%0d: got %b expected 1", s, d_valid); end
         tick();
         d_read = 1'b0; d_write = 1'b0; mem_ready = 1'b0;
         #1;
         checks++; if (d_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rw_single s=%0d: got dv=%b req=%b expected 0 0", s, d_valid, mem_req); end
      end
   endtask

   task automatic test_timeout();
      idle_inputs();
      tick();
      d_read = 1'b1; d_write = 1'b0; d_addr = 32'h0000_0300; d_size = 2'd2;
      tick();
      for (int k = 0; k < int'(TO); k++) begin
         mem_rdata = 32'hBAD0_0000 | 32'(k);
         #1;
         checks++; if (mem_req !== 1'b1 || d_valid !== (k == int'(TO) - 1) || err_timeout !== 1'b0) begin errors++; $display("FAIL to_busy k=%0d: got req=%b dv=%b err=%b", k, mem_req, d_valid, err_timeout); end
         if (k == int'(TO) - 1) begin
            checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h expected 0", d_rdata); end
         end
         tick();
      end
      d_read = 1'b0;
      #1;
      checks++; if (err_timeout !== 1'b1 || mem_req !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("FAIL to_after: got err=%b req=%b dv=%b expected 1 0 0", err_timeout, mem_req, d_valid); end
      tick();
      tick();
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", err_timeout); end
      if_req = 1'b1; if_addr = 32'h0000_0044;
      tick();
      mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
      #1;
      checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h0050_0093 || mem_addr !== 32'h44 || err_timeout !== 1'b1) begin errors++; $display("FAIL to_next: got iv=%b rd=%h addr=%h err=%b", if_valid, if_rdata, mem_addr, err_timeout); end
      tick();
      if_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      tick();
      if_req = 1'b1; if_addr = 32'h0000_0080;
      tick();
      #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin errors++; $display("FAIL rm_grant: got req=%b addr=%h expected 1 00000080", mem_req, mem_addr); end
      tick();
      tick();
      RST = 1'b1;
      #1;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rm_no_valid: got %b expected 0", if_valid); end
      tick();
      RST = 1'b0; if_req = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || if_valid !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL rm_cleared: got req=%b addr=%h iv=%b err=%b", mem_req, mem_addr, if_valid, err_timeout); end
      mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      #1;
      checks++; if (if_valid !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("FAIL rm_stray: got iv=%b dv=%b expected 0 0", if_valid, d_valid); end
      tick();
      checks++; if (mem_req !== 1'b0 || if_valid !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("FAIL rm_stray2: got req=%b iv=%b dv=%b", mem_req, if_valid, d_valid); end
      mem_ready = 1'b0;
   endtask

   // Transaction-level model: data before fetch, completion after min(wait, TO-1)
   // busy cycles, timeouts return zero and set the sticky error.
   task automatic test_random_traffic();
      bit          use_if, use_d, dwe, exp_err, pend_if, pend_d, tmo, own_d;
      int          op, ng, w, dk;
      bit          g_is_d [2];
      logic [31:0] ia, da, dw, rd, exp_a, got_rd;
      logic [1:0]  ds, exp_sz;
      exp_err = 1'b0;
      idle_inputs();
      tick();
      for (int it = 0; it < 40; it++) begin
         use_d  = 1'($urandom_range(0, 1));
         use_if = use_d ? 1'($urandom_range(0, 1)) : 1'b1;
         op  = int'($urandom_range(0, 2));
         ia  = $urandom & 32'hFFFF_FFFC;
         da  = $urandom;
         dw  = $urandom;
         ds  = 2'($urandom_range(0, 2));
         dwe = (op != 0);
         if_req = use_if; if_addr = ia;
         d_read = use_d && (op != 1); d_write = use_d && (op != 0);
         d_addr = da; d_wdata = dw; d_size = ds;
         pend_if = use_if; pend_d = use_d;
         ng = 0;
         if (use_d)  begin g_is_d[ng] = 1'b1; ng++; end
         if (use_if) begin g_is_d[ng] = 1'b0; ng++; end
         for (int g = 0; g < ng; g++) begin
            own_d = g_is_d[g];
            w   = int'($urandom_range(0, 5));
            tmo = (w >= int'(TO));
            dk  = tmo ? int'(TO) - 1 : w;
            exp_a  = own_d ? da : ia;
            exp_sz = own_d ? ds : 2'd2;
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            checks++; if (mem_req !== 1'b0 || if_valid !== 1'b0 || d_valid !== 1'b0 || err_timeout !== exp_err) begin errors++; $display("FAIL rnd_idle it=%0d: got req=%b iv=%b dv=%b err=%b expected 0 0 0 %b", it, mem_req, if_valid, d_valid, err_timeout, exp_err); end
            checks++; if (stall_if !== pend_if || stall_mem !== pend_d) begin errors++; $display("FAIL rnd_idle_stall it=%0d: got %b%b expected %b%b", it, stall_if, stall_mem, pend_if, pend_d); end
            tick();
            for (int k = 0; k <= dk; k++) begin
               mem_ready = (k == w);
               rd = $urandom;
               mem_rdata = rd;
               #1;
               checks++; if (mem_req !== 1'b1 || mem_we !== (own_d && dwe) || mem_addr !== exp_a || mem_size !== exp_sz || (own_d && dwe && mem_wdata !== dw)) begin errors++; $display("FAIL rnd_fields it=%0d k=%0d: got we=%b addr=%h sz=%0d wd=%h expected %b %h %0d", it, k, mem_we, mem_addr, mem_size, mem_wdata, own_d && dwe, exp_a, exp_sz); end
               checks++; if (d_valid !== (own_d && k == dk) || if_valid !== (!own_d && k == dk)) begin errors++; $display("FAIL rnd_valid it=%0d k=%0d: got dv=%b iv=%b dk=%0d own_d=%b", it, k, d_valid, if_valid, dk, own_d); end
               checks++; if (stall_mem !== (own_d ? (k != dk) : pend_d) || stall_if !== (own_d ? pend_if : (k != dk))) begin errors++; $display("FAIL rnd_stall it=%0d k=%0d: got sif=%b smem=%b", it, k, stall_if, stall_mem); end
               if (k == dk) begin
                  got_rd = own_d ? d_rdata : if_rdata;
                  checks++; if (got_rd !== (tmo ? 32'h0 : rd)) begin errors++; $display("FAIL rnd_rdata it=%0d: got %h expected %h", it, got_rd, tmo ? 32'h0 : rd); end
               end
               tick();
            end
            if (own_d) begin d_read = 1'b0; d_write = 1'b0; pend_d = 1'b0; end
            else begin if_req = 1'b0; pend_if = 1'b0; end
            if (tmo) exp_err = 1'b1;
            mem_ready = 1'b0;
         end
      end
      #1;
      checks++; if (mem_req !== 1'b0 || err_timeout !== exp_err) begin errors++; $display("FAIL rnd_end: got req=%b err=%b expected 0 %b", mem_req, err_timeout, exp_err); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_contention();
      test_zero_wait();
      test_both_rw();
      test_timeout();
      test_reset_mid();
      test_random_traffic();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
